sv_multichan_top: RTL and testbench
===================================

Name: sv_multichan_top

Overview:
- Parametrised multi-channel successor to the single-instance counter/signal-pass top used in the interface regression flow.
- Contains CH independent channels. Each channel has a configurable-width event counter with wrap or saturate mode, plus a DEPTH-stage registered delay line for its sig lane.
- Serves as the DUT for interface-array and generate-loop regressions. Sits at top level and is driven directly by a bench.

Parameters:
- CH, 2, number of channels (1..8)
- CW, 22, counter width per channel (2..32)
- SW, 2, sig lane width per channel (1..16)
- DEPTH, 1, sig delay-line stages (1..8)
- STEP, 1, counter increment per enabled cycle (1..2^CW-1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  CH  per-channel count enable
- clr  in  CH  per-channel synchronous counter clear
- mode  in  CH  per-channel mode; 0 = wrap, 1 = saturate
- sig  in  CH*SW  packed sig lanes; channel c occupies bits [c*SW +: SW]
- sig_out  out  CH*SW  delayed sig lanes, same packing as sig
- outOther  out  CH*CW  packed counters; channel c occupies bits [c*CW +: CW]
- wrap_pulse  out  CH  one-cycle pulse on counter wrap (wrap mode only)
- sat_flag  out  CH  sticky flag: counter has reached its maximum in saturate mode

Behaviour:
- Reset: rst is sampled at the rising edge of clk and is active-low. While rst=0 at an edge, all outputs clear to 0 on that edge: outOther, sig_out, wrap_pulse, sat_flag, and every delay-line stage. Reset overrides all other inputs. Asserting reset mid-count clears the channel immediately. No state survives reset.
- Counter, per channel. Priority order per edge:
  - clr=1: counter ← 0, sat_flag ← 0, wrap_pulse ← 0. clr applies even if en=0.
  - else en=1, mode=0 (wrap): counter ← (counter + STEP) mod 2^CW. wrap_pulse ← 1 iff counter + STEP ≥ 2^CW; otherwise 0.
  - else en=1, mode=1 (saturate): counter ← min(counter + STEP, 2^CW-1). sat_flag ← 1 once the result equals 2^CW-1. wrap_pulse ← 0.
  - else (en=0): counter holds, wrap_pulse ← 0.
- Arithmetic:
  - The sum is computed in CW+1 bits; the carry is the wrap/saturation detect.
  - No output depends combinationally on inputs; all outputs are registered.
- Mode change mid-count takes effect on the next enabled edge. The current counter value is kept.
- sat_flag stays set until clr or reset, even if mode returns to 0.
- Delay line, per channel:
  - sig_out lane c equals sig lane c sampled DEPTH rising edges earlier.
  - The delay line shifts every cycle regardless of en, clr or mode.
  - During the first DEPTH cycles after reset release, sig_out is 0.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Latency:
  - counter: 1 cycle from en to the updated outOther.
  - sig: DEPTH cycles.
  - wrap_pulse: coincides with the outOther update that wrapped.

Decomposition:
- Package sv_multichan_pkg holds:
  - the mode enum (MODE_WRAP=0, MODE_SAT=1);
  - a parameter-check function that flags out-of-range CH, CW, SW, DEPTH, STEP at elaboration.
- Sub-module sv_chan_unit implements one channel: counter, flags and delay line, parametrised by CW, SW, DEPTH, STEP.
- The top level is a generate loop over CH instances of sv_chan_unit plus bus packing.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then rst=1 with en=0 and sig=0 → all outputs 0 for 5 cycles.
- Wrap: CW=4, STEP=3, mode=0, en=1 from 0 → counter sequence 3,6,9,12,15,2. wrap_pulse=1 only on the cycle outOther becomes 2.
- Saturate: CW=4, STEP=5, mode=1 → counter sequence 5,10,15,15. sat_flag=1 from the cycle outOther=15 onward. A later clr=1 → counter 0 and sat_flag 0 on the next edge.
- Delay/independence: CH=2, DEPTH=3.
  - Drive sig ch0 with 1,2,3 on successive cycles → sig_out ch0 shows 1,2,3 starting 3 cycles later.
  - Hold ch1 en=0 → ch1 outOther stays 0 while ch0 counts.
- Priority and mid-op reset:
  - clr=1 and en=1 on the same edge → counter 0.
  - rst=0 asserted while counter=7 and the delay line is full → all outputs 0 on the next edge, pipeline flushed.
- Default parameters (CH=2, CW=22, SW=2, DEPTH=1):
  - sig=2'b00 with rst released after the first edge → sig_out=0 for 3 edges.
  - With en=1, outOther counts 1,2,3.

Source files
------------

// File: rtl/sv_multichan_pkg.sv
// sv_multichan_pkg: shared mode encoding and parameter range check for the multi-channel counter block
package sv_multichan_pkg;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;
  function automatic bit params_ok(int ch, int cw, int sw, int depth, int unsigned step);
    return ch inside {[1:8]} && cw inside {[2:32]} && sw inside {[1:16]} &&
           depth inside {[1:8]} && step >= 1 && longint'(step) < (longint'(1) << cw);
  endfunction
endpackage

// File: rtl/sv_chan_unit.sv
// sv_chan_unit: one channel - wrap/saturate event counter with sticky flag, plus a sig delay line
module sv_chan_unit import sv_multichan_pkg::*; #(
  parameter int          CW    = 22,
  parameter int          SW    = 2,
  parameter int          DEPTH = 1,
  parameter int unsigned STEP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          mode,
  input  logic [SW-1:0] sig,
  output logic [SW-1:0] sig_out,
  output logic [CW-1:0] cnt,
  output logic          wrap_pulse,
  output logic          sat_flag
);
  logic [CW:0]   sum;
  logic [CW-1:0] cnt_q, cnt_d, sat_val;
  logic          wrap_q, wrap_d, sat_q, sat_d, sat_mode;
  logic [SW-1:0] dly_q [DEPTH];
  logic [SW-1:0] dly_d [DEPTH];
  always_comb begin
    sat_mode = mode_e'(mode) == MODE_SAT;
    // the carry out of the CW+1 bit sum is both the wrap and the saturation detect
    sum      = {1'b0, cnt_q} + (CW+1)'(STEP);
    sat_val  = sum[CW] ? '1 : sum[CW-1:0];
    cnt_d    = clr ? '0 : !en ? cnt_q : sat_mode ? sat_val : sum[CW-1:0];
    wrap_d   = !clr && en && !sat_mode && sum[CW];
    sat_d    = !clr && (sat_q || (en && sat_mode && &sat_val));
    dly_d[0] = sig;
    for (int i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
      dly_q  <= '{default: '0};
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
      dly_q  <= dly_d;
    end
  end
  assign cnt        = cnt_q;
  assign wrap_pulse = wrap_q;
  assign sat_flag   = sat_q;
  assign sig_out    = dly_q[DEPTH-1];
endmodule

// File: rtl/sv_multichan_top.sv
// sv_multichan_top: CH independent counter/delay channels packed onto flat buses
module sv_multichan_top import sv_multichan_pkg::*; #(
  parameter int          CH    = 2,
  parameter int          CW    = 22,
  parameter int          SW    = 2,
  parameter int          DEPTH = 1,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic [CH-1:0]    clr,
  input  logic [CH-1:0]    mode,
  input  logic [CH*SW-1:0] sig,
  output logic [CH*SW-1:0] sig_out,
  output logic [CH*CW-1:0] outOther,
  output logic [CH-1:0]    wrap_pulse,
  output logic [CH-1:0]    sat_flag
);
  if (!params_ok(CH, CW, SW, DEPTH, STEP)) begin : g_bad
    $error("sv_multichan_top: parameter out of range");
  end
  for (genvar c = 0; c < CH; c++) begin : g_ch
    sv_chan_unit #(.CW(CW), .SW(SW), .DEPTH(DEPTH), .STEP(STEP)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en[c]),
      .clr        (clr[c]),
      .mode       (mode[c]),
      .sig        (sig[c*SW +: SW]),
      .sig_out    (sig_out[c*SW +: SW]),
      .cnt        (outOther[c*CW +: CW]),
      .wrap_pulse (wrap_pulse[c]),
      .sat_flag   (sat_flag[c])
    );
  end
endmodule

// File: tb/tb_sv_multichan_top.sv
// tb_sv_multichan_top: three parameterisations driven in lockstep and checked against a behavioural model
module tb_sv_multichan_top;
  logic clk = 0, rst = 0;
  logic [1:0] en = 0, clr = 0, mode = 0;
  logic [7:0] sig = 0;
  logic [7:0] soa, sob, oa, ob;
  logic [3:0] soc;
  logic [43:0] oc;
  logic [1:0] wa, wb, wc, sa, sb, sc;
  int n_vec = 0, n_err = 0;
  int cw_p[3]  = '{4, 4, 22};
  int stp_p[3] = '{3, 5, 1};
  int dep_p[3] = '{3, 3, 1};
  int sw_p[3]  = '{4, 4, 2};
  longint cnt_m[3][2];
  bit wr_m[3][2], sa_m[3][2];
  logic [7:0] hist[8];
  int age = 0;
  always #5 clk = ~clk;
  sv_multichan_top #(.CH(2), .CW(4), .SW(4), .DEPTH(3), .STEP(3)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .sig(sig),
    .sig_out(soa), .outOther(oa), .wrap_pulse(wa), .sat_flag(sa));
  sv_multichan_top #(.CH(2), .CW(4), .SW(4), .DEPTH(3), .STEP(5)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .sig(sig),
    .sig_out(sob), .outOther(ob), .wrap_pulse(wb), .sat_flag(sb));
  sv_multichan_top dut_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .sig({sig[5:4], sig[1:0]}),
    .sig_out(soc), .outOther(oc), .wrap_pulse(wc), .sat_flag(sc));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model();
    longint lim, s;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        lim = (longint'(1) << cw_p[d]) - 1;
        s = cnt_m[d][c] + stp_p[d];
        if (!rst) begin
          cnt_m[d][c] = 0; wr_m[d][c] = 0; sa_m[d][c] = 0;
        end else if (clr[c]) begin
          cnt_m[d][c] = 0; wr_m[d][c] = 0; sa_m[d][c] = 0;
        end else if (en[c] && mode[c]) begin
          cnt_m[d][c] = s > lim ? lim : s;
          if (cnt_m[d][c] == lim) sa_m[d][c] = 1;
          wr_m[d][c] = 0;
        end else if (en[c]) begin
          wr_m[d][c] = s > lim;
          cnt_m[d][c] = s % (lim + 1);
        end else wr_m[d][c] = 0;
      end
    if (!rst) age = 0;
    else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sig;
      age++;
    end
  endtask
  task automatic compare();
    logic [63:0] ec, ew, es, eso, gc, gw, gs, gso;
    logic [7:0] h;
    for (int d = 0; d < 3; d++) begin
      ec = 0; ew = 0; es = 0; eso = 0;
      h = age >= dep_p[d] ? hist[dep_p[d]-1] : 8'h0;
      for (int c = 0; c < 2; c++) begin
        ec |= 64'(cnt_m[d][c]) << (c * cw_p[d]);
        ew[c] = wr_m[d][c];
        es[c] = sa_m[d][c];
        eso |= 64'((h >> (c * 4)) & ((1 << sw_p[d]) - 1)) << (c * sw_p[d]);
      end
      gc  = d == 0 ? 64'(oa)  : d == 1 ? 64'(ob)  : 64'(oc);
      gw  = d == 0 ? 64'(wa)  : d == 1 ? 64'(wb)  : 64'(wc);
      gs  = d == 0 ? 64'(sa)  : d == 1 ? 64'(sb)  : 64'(sc);
      gso = d == 0 ? 64'(soa) : d == 1 ? 64'(sob) : 64'(soc);
      chk($sformatf("cnt%0d", d), gc, ec);
      chk($sformatf("wrap%0d", d), gw, ew);
      chk($sformatf("sat%0d", d), gs, es);
      chk($sformatf("sigout%0d", d), gso, eso);
    end
  endtask
  task automatic step(input bit r, input logic [1:0] e, input logic [1:0] c,
                      input logic [1:0] m, input logic [7:0] s);
    @(negedge clk);
    rst = r; en = e; clr = c; mode = m; sig = s;
    @(posedge clk);
    model();
    #1 compare();
  endtask
  initial begin
    for (int i = 0; i < 8; i++) hist[i] = 0;
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) step(1, 2'b01, 0, 0, i <= 3 ? 8'(i) : 8'h0);
    chk("wrap_val_a", 64'(oa[3:0]), 64'd2);
    chk("wrap_pulse_a", 64'(wa), 64'd1);
    chk("idle_ch1_a", 64'(oa[7:4]), 64'd0);
    step(1, 2'b00, 2'b11, 0, 0);
    repeat (6) step(1, 2'b11, 0, 2'b11, 8'h5a);
    chk("sat_val_a", 64'(oa), 64'hff);
    chk("sat_flag_b", 64'(sb), 64'd3);
    step(1, 2'b01, 2'b01, 2'b00, 8'h33);
    chk("clr_pri_a", 64'(oa[3:0]), 64'd0);
    repeat (2) step(1, 2'b01, 0, 2'b00, 8'hc7);
    step(0, 2'b11, 0, 0, 8'hff);
    chk("midrst_a", 64'(oa), 64'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) != 0, 2'($urandom), 2'($urandom_range(0, 9) == 0 ? $urandom : 0),
           2'($urandom), 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
